// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and constants for the two-port memory arbiter.
//   arb_state_t : FSM state encoding (IDLE / ACCESS / RESP)
//   PORT_CPU    : index of port 0 (CPU)
//   PORT_AUX    : index of port 1 (loader/debug)
//   STREAK_W    : width of the consecutive-grant counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick -- combinational winner selection for mem_arbiter.
// Ports:
//   p0_req, p1_req   : request lines of the two ports
//   last_winner      : port granted most recently
//   streak_at_limit  : last_winner has used up its burst allowance
//   winner           : selected port index
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin for simultaneous
// requests; without it port 0 has fixed priority. The burst limit applies
// in both builds.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic p0_req,
    input  logic p1_req,
    input  logic last_winner,
    input  logic streak_at_limit,
    output logic winner
);

    always_comb begin
        winner = PORT_CPU;
        if (p0_req && p1_req) begin
            // The burst limit forces a hand-over before the normal policy.
            if (streak_at_limit) begin
                winner = ~last_winner;
            end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                winner = ~last_winner;
`else
                winner = PORT_CPU;
`endif
            end
        end else if (p1_req) begin
            winner = PORT_AUX;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port arbiter in front of a single-ported memory.
// Each access takes IDLE -> ACCESS -> RESP, one cycle each.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   pN_req/we/addr/wdata       : request from port N (0 = CPU, 1 = aux)
//   pN_done, pN_rdata          : completion pulse and read data of port N
//   mem_addr, mem_wdata        : latched access address / write data
//   mem_read, mem_write        : one-cycle memory strobes (ACCESS only)
//   mem_rdata                  : memory read data, valid cycle after mem_read
//   busy                       : high whenever the FSM is not IDLE
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
// BURST_MAX must lie in 1..15 to fit the streak counter.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_done,
    output logic              p1_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // state  | meaning
    // IDLE   | waiting for a request; winner chosen and latched here
    // ACCESS | latched address/data on the bus, one read or write strobe
    // RESP   | memory data returned to the winner, winner's done pulses

    localparam logic [STREAK_W-1:0] BURST_LIM = STREAK_W'(BURST_MAX);

    arb_state_t          state;
    logic                winner_q;
    logic                we_q;
    logic                last_winner;
    logic [STREAK_W-1:0] streak;
    logic [DATA_W-1:0]   p0_rdata_q;
    logic [DATA_W-1:0]   p1_rdata_q;
    logic                pick;
    logic                at_limit;

    assign at_limit = (streak == BURST_LIM);

    mem_arb_pick u_pick (
        .p0_req          (p0_req),
        .p1_req          (p1_req),
        .last_winner     (last_winner),
        .streak_at_limit (at_limit),
        .winner          (pick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            winner_q    <= PORT_CPU;
            we_q        <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            streak      <= '0;
            last_winner <= PORT_AUX;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        winner_q    <= pick;
                        we_q        <= pick ? p1_we    : p0_we;
                        mem_addr    <= pick ? p1_addr  : p0_addr;
                        mem_wdata   <= pick ? p1_wdata : p0_wdata;
                        last_winner <= pick;
                        // Saturate so a lone requester keeps the limit flag set.
                        if (pick == last_winner) begin
                            streak <= at_limit ? streak : streak + 1'b1;
                        end else begin
                            streak <= STREAK_W'(1);
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: state <= RESP;
                RESP: begin
                    if (winner_q == PORT_CPU) p0_rdata_q <= mem_rdata;
                    else                      p1_rdata_q <= mem_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign mem_read  = (state == ACCESS) && !we_q;
    assign mem_write = (state == ACCESS) &&  we_q;
    assign p0_done   = (state == RESP) && (winner_q == PORT_CPU);
    assign p1_done   = (state == RESP) && (winner_q == PORT_AUX);

    // Memory data only arrives during RESP, so the done cycle forwards it
    // directly; the register keeps it afterwards.
    assign p0_rdata  = p0_done ? mem_rdata : p0_rdata_q;
    assign p1_rdata  = p1_done ? mem_rdata : p1_rdata_q;

endmodule
